conv3x3_stream: RTL and testbench

Streaming 3x3 convolution stage sitting directly upstream of the normalization stage. It accepts one 8-bit unsigned grayscale pixel per valid cycle in raster order and buffers two image lines internally. For every fully populated 3x3 window it emits a signed 21-bit filter sum in the range -510..1530, which the normalization stage maps onto 0..255. Edge pixels are not padded; the output image is (IMG_W-2) x (IMG_H-2).

---
 rtl/img_pkg.sv | 18 +
 rtl/line_buffer.sv | 44 ++++
 rtl/conv3x3_stream.sv | 119 +++++++++++
 tb/tb_conv3x3_stream.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/img_pkg.sv
// Shared image-pipeline constants: pixel/normalization widths, the fixed 3x3 kernel
// and the filter sum range that the normalization stage maps onto 0..255.
package img_pkg;

    localparam int norm_width = 20;
    localparam int PIX_W      = 8;

    // Rows top to bottom; the datapath realises these with shifts and adds only.
    localparam logic signed [3:0] KERNEL [3][3] = '{
        '{ 4'sd0, -4'sd1,  4'sd0},
        '{ 4'sd1,  4'sd4,  4'sd1},
        '{ 4'sd0, -4'sd1,  4'sd0}
    };

    localparam int CONV_MAX = 1530;
    localparam int CONV_MIN = -510;

endpackage

// File: rtl/line_buffer.sv
// Circular single-address line delay; read-before-write so dout is the value written DEPTH enables ago.
// Zero latency on the read path, advances only on en, no backpressure.
module line_buffer #(
    parameter int DEPTH = 640,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] ADDR_LAST = AW'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    addr_q, addr_d;

    always_comb begin
        addr_d = addr_q;
        if (en) begin
            addr_d = (addr_q == ADDR_LAST) ? '0 : addr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

    // RAM contents are left untouched by reset; only the address restarts.
    always_ff @(posedge clk) begin
        if (en) begin
            mem_q[addr_q] <= din;
        end
    end

    assign dout = mem_q[addr_q];

endmodule

// File: rtl/conv3x3_stream.sv
// Streaming 3x3 [0 -1 0; 1 4 1; 0 -1 0] filter over raster pixels; result 2 edges after the completing pixel.
// No backpressure: pix_valid gaps stall the window while the sum pipeline keeps draining.
module conv3x3_stream
    import img_pkg::*;
#(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int PIX_W = img_pkg::PIX_W,
    parameter int OUT_W = norm_width + 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [PIX_W-1:0]        pix_in,
    input  logic                    pix_valid,
    input  logic                    frame_start,
    output logic signed [OUT_W-1:0] conv_out,
    output logic                    conv_valid,
    output logic                    frame_done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    logic [CW-1:0]           col_q, col_d, cur_col;
    logic [RW-1:0]           row_q, row_d, cur_row;
    logic [PIX_W-1:0]        win_q [3][3];
    logic [PIX_W-1:0]        win_d [3][3];
    logic [1:0]              vld_q, vld_d;
    logic [1:0]              last_q, last_d;
    logic signed [OUT_W-1:0] ptb_q, ptb_d, plr_q, plr_d, pc_q, pc_d;
    logic signed [OUT_W-1:0] conv_out_q, conv_out_d;
    logic                    conv_valid_q, conv_valid_d;
    logic                    frame_done_q, frame_done_d;
    logic [PIX_W-1:0]        lb1_dout, lb2_dout;

    line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb1 (
        .clk(clk), .reset(reset), .en(pix_valid), .din(pix_in), .dout(lb1_dout)
    );

    line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb2 (
        .clk(clk), .reset(reset), .en(pix_valid), .din(lb1_dout), .dout(lb2_dout)
    );

    function automatic logic signed [OUT_W-1:0] ext(input logic [PIX_W-1:0] p);
        return signed'({{(OUT_W - PIX_W){1'b0}}, p});
    endfunction

    always_comb begin
        // frame_start only matters on an accepted pixel, where it pins the position to (0,0).
        cur_col = frame_start ? '0 : col_q;
        cur_row = frame_start ? '0 : row_q;
        col_d   = col_q;
        row_d   = row_q;
        win_d   = win_q;
        vld_d   = {vld_q[0], 1'b0};
        last_d  = {last_q[0], 1'b0};
        if (pix_valid) begin
            col_d = (cur_col == COL_LAST) ? '0 : cur_col + 1'b1;
            row_d = cur_row;
            if (cur_col == COL_LAST) begin
                row_d = (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;
            end
            for (int r = 0; r < 3; r++) begin
                win_d[r][0] = win_q[r][1];
                win_d[r][1] = win_q[r][2];
            end
            win_d[0][2] = lb2_dout;
            win_d[1][2] = lb1_dout;
            win_d[2][2] = pix_in;
            vld_d[0]    = (cur_row >= ROW_TWO) && (cur_col >= COL_TWO);
            last_d[0]   = (cur_row == ROW_LAST) && (cur_col == COL_LAST);
        end

        ptb_d = ext(win_q[0][1]) + ext(win_q[2][1]);
        plr_d = ext(win_q[1][0]) + ext(win_q[1][2]);
        pc_d  = ext(win_q[1][1]) <<< 2;

        conv_valid_d = vld_q[1];
        frame_done_d = vld_q[1] & last_q[1];
        conv_out_d   = vld_q[1] ? (pc_q + plr_q - ptb_q) : conv_out_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            col_q        <= '0;
            row_q        <= '0;
            win_q        <= '{default: '0};
            vld_q        <= '0;
            last_q       <= '0;
            ptb_q        <= '0;
            plr_q        <= '0;
            pc_q         <= '0;
            conv_out_q   <= '0;
            conv_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            win_q        <= win_d;
            vld_q        <= vld_d;
            last_q       <= last_d;
            ptb_q        <= ptb_d;
            plr_q        <= plr_d;
            pc_q         <= pc_d;
            conv_out_q   <= conv_out_d;
            conv_valid_q <= conv_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign conv_out   = conv_out_q;
    assign conv_valid = conv_valid_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_conv3x3_stream.sv
// Scoreboard bench for conv3x3_stream on an 8x6 image: expected sums are computed from the
// driven image when each pixel is sent and matched against DUT outputs in order.
module tb_conv3x3_stream;

    localparam int W = 8;
    localparam int H = 6;

    typedef struct {
        int val;
        int last;
    } exp_t;

    logic               clk = 1'b0;
    logic               reset;
    logic [7:0]         pix_in;
    logic               pix_valid;
    logic               frame_start;
    logic signed [20:0] conv_out;
    logic               conv_valid;
    logic               frame_done;

    exp_t exp_q[$];
    int   got_q[$];
    int   ref_q[$];
    int   img [H][W];
    int   mr, mc;
    int   n_vec, n_err;
    int   n_pulse, n_fd;

    conv3x3_stream #(.IMG_W(W), .IMG_H(H), .PIX_W(8), .OUT_W(21)) dut (
        .clk(clk), .reset(reset), .pix_in(pix_in), .pix_valid(pix_valid),
        .frame_start(frame_start), .conv_out(conv_out), .conv_valid(conv_valid),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic send(input int p, input bit fs);
        exp_t e;
        @(negedge clk);
        pix_in      = 8'(p);
        pix_valid   = 1'b1;
        frame_start = fs;
        if (fs) begin
            mr = 0;
            mc = 0;
        end
        img[mr][mc] = p;
        if (mr >= 2 && mc >= 2) begin
            e.val  = 4 * img[mr-1][mc-1] + img[mr-1][mc-2] + img[mr-1][mc]
                   - img[mr-2][mc-1] - img[mr][mc-1];
            e.last = (mr == H - 1 && mc == W - 1) ? 1 : 0;
            exp_q.push_back(e);
        end
        if (mc == W - 1) begin
            mc = 0;
            mr = (mr == H - 1) ? 0 : mr + 1;
        end else begin
            mc = mc + 1;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            pix_valid   = 1'b0;
            frame_start = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (conv_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", int'(conv_valid), 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("conv_out", int'(conv_out), e.val);
                    chk("frame_done", int'(frame_done), e.last);
                    got_q.push_back(int'(conv_out));
                    n_pulse++;
                    if (frame_done) n_fd++;
                end
            end else if (frame_done) begin
                chk("frame_done_idle", int'(frame_done), 0);
            end
        end
    end

    initial begin
        n_vec = 0; n_err = 0; n_pulse = 0; n_fd = 0;
        mr = 0; mc = 0;
        reset = 1'b1; pix_in = '0; pix_valid = 1'b0; frame_start = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_conv_out", int'(conv_out), 0);
        chk("rst_conv_valid", int'(conv_valid), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        reset = 1'b0;

        // Constant frame
        for (int i = 0; i < W * H; i++) send(100, i == 0);
        idle(4);
        chk("const_pulses", n_pulse, 24);
        chk("const_fd", n_fd, 1);
        chk("const_val", got_q[0], 400);

        // Alternating rows: even rows 255, odd rows 0 -> extremes
        got_q.delete();
        for (int i = 0; i < W * H; i++) send(((i / W) % 2 == 0) ? 255 : 0, i == 0);
        idle(4);
        chk("min_win", got_q[0], -510);
        chk("max_win", got_q[6], 1530);

        // Ramp, gap-free
        got_q.delete();
        for (int i = 0; i < W * H; i++) send((i % W) * 10 + i / W, i == 0);
        idle(4);
        chk("ramp_c22", got_q[7], 88);
        ref_q = got_q;

        // Ramp with random gaps and an isolated pixel for latency
        got_q.delete();
        for (int i = 0; i < W * H; i++) begin
            if (i == 3 * W + 3) begin
                idle(3);
                send((i % W) * 10 + i / W, 1'b0);
                idle(1);
                chk("lat_e0", int'(conv_valid), 0);
                @(negedge clk);
                chk("lat_e1", int'(conv_valid), 0);
                @(negedge clk);
                chk("lat_e2", int'(conv_valid), 1);
            end else begin
                send((i % W) * 10 + i / W, i == 0);
                if ($urandom_range(2, 0) == 0) idle($urandom_range(3, 1));
            end
        end
        idle(4);
        chk("gap_count", got_q.size(), ref_q.size());
        for (int i = 0; i < got_q.size() && i < ref_q.size(); i++) chk("gap_eq", got_q[i], ref_q[i]);

        // frame_start at row 3 col 5 resynchronises
        n_pulse = 0; n_fd = 0;
        for (int i = 0; i < 3 * W + 5; i++) send($urandom_range(255, 0), i == 0);
        for (int i = 0; i < W * H; i++) send($urandom_range(255, 0), i == 0);
        idle(4);
        chk("resync_pulses", n_pulse, 33);
        chk("resync_fd", n_fd, 1);

        // Reset mid-frame while conv_valid is high
        for (int i = 0; i < 3 * W + 5; i++) send($urandom_range(255, 0), i == 0);
        idle(1);
        #1;
        chk("rst_pre_vld", int'(conv_valid), 1);
        reset = 1'b1;
        exp_q.delete();
        mr = 0; mc = 0;
        @(negedge clk);
        chk("rst_mid_vld", int'(conv_valid), 0);
        chk("rst_mid_out", int'(conv_out), 0);
        reset = 1'b0;
        n_pulse = 0; n_fd = 0;
        for (int i = 0; i < W * H; i++) send($urandom_range(255, 0), 1'b0);
        idle(4);
        chk("post_rst_pulses", n_pulse, 24);
        chk("post_rst_fd", n_fd, 1);
        chk("queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
